// File: rtl/fm_pac_mapper_mc_if.sv
// -----------------------------------------------------------------------------
// fm_pac_mapper_mc_if
//   OPLL write handshake bundle between the FM-PAC mapper and the OPLL cores.
//   One lane per channel; channel c data lives at opll_d[8c+7:8c].
//
//   opll_io_enable : per-channel enable[0] (OPLL I/O ports enabled)
//   opll_valid     : head entry of channel c is presented
//   opll_a0        : head entry register(0)/data(1) select
//   opll_d         : head entry data
//   opll_ready     : OPLL core accepts the head entry
//
//   Handshake: a channel's entry transfers on a clock edge where
//   opll_valid[c] & opll_ready[c] are both high; while valid is high and
//   ready is low, opll_a0/opll_d stay stable. Valid never waits for ready.
// -----------------------------------------------------------------------------
interface fm_pac_mapper_mc_if #(
   parameter int CHANNELS = 2
);
   logic [CHANNELS-1:0]   opll_io_enable;
   logic [CHANNELS-1:0]   opll_valid;
   logic [CHANNELS-1:0]   opll_a0;
   logic [8*CHANNELS-1:0] opll_d;
   logic [CHANNELS-1:0]   opll_ready;

   modport master (
      output opll_io_enable,
      output opll_valid,
      output opll_a0,
      output opll_d,
      input  opll_ready
   );

   modport slave (
      input  opll_io_enable,
      input  opll_valid,
      input  opll_a0,
      input  opll_d,
      output opll_ready
   );
endinterface

// File: rtl/fm_pac_mapper_mc.sv
// -----------------------------------------------------------------------------
// fm_pac_mapper_mc
//   Multi-channel FM-PAC cartridge mapper. Per channel it holds the enable,
//   ROM bank and SRAM magic registers, decodes the register window, builds
//   ROM/SRAM addresses and forwards OPLL register writes to the OPLL core.
//
//   Optional feature macro: FMPAC_OPLL_FIFO_EN
//     defined   : per-channel OPLL write FIFO (FIFO_DEPTH entries) with a
//                 valid/ready handshake and a sticky overflow flag.
//     undefined : each OPLL write gives a one-cycle opll_valid pulse with
//                 registered a0/data; opll_ready is ignored, ovf reads 0.
//
//   Ports
//     clk, reset_n          : clock, asynchronous active-low reset
//     addr, d_from_cpu      : CPU address / write data
//     d_to_cpu, cart_oe     : register read data (FFh when not driving)
//     cs, slot              : slot select and channel index
//     wr, rd, mreq          : CPU strobes, active high
//     sram_oe, sram_we      : unlocked SRAM window hit / write strobe
//     mem_unmaped           : cs with addr outside 4000h-7FFFh
//     mem_addr              : ROM/SRAM address of the selected channel
//     opll                  : OPLL write handshake (master side)
// -----------------------------------------------------------------------------
module fm_pac_mapper_mc #(
   parameter int  CHANNELS   = 2,
   parameter int  SRAM_AW    = 13,
   parameter int  BANK_W     = 2,
   parameter int  FIFO_DEPTH = 4,
   localparam int SLOT_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        addr,
   input  logic [7:0]         d_from_cpu,
   output logic [7:0]         d_to_cpu,
   input  logic               cs,
   input  logic [SLOT_W-1:0]  slot,
   input  logic               wr,
   input  logic               rd,
   input  logic               mreq,
   output logic               cart_oe,
   output logic               sram_oe,
   output logic               sram_we,
   output logic               mem_unmaped,
   output logic [24:0]        mem_addr,
   fm_pac_mapper_mc_if.master opll
);

   localparam logic [15:0] SRAM_MAGIC = 16'h694D;

   // per-channel register file
   logic [7:0]          enable_q [CHANNELS];
   logic [7:0]          enable_d [CHANNELS];
   logic [BANK_W-1:0]   bank_q   [CHANNELS];
   logic [BANK_W-1:0]   bank_d   [CHANNELS];
   logic [15:0]         magic_q  [CHANNELS];
   logic [15:0]         magic_d  [CHANNELS];
   logic                acc_q, acc_d;

   logic                slot_ok;
   logic [SLOT_W-1:0]   sel;
   logic [13:0]         reg_a;
   logic                acc;
   logic                wr_ev;
   logic                push;
   logic                sram_en;
   logic                rd_hit;
   logic [7:0]          rdata;

   // per-channel status / OPLL lane values produced by either build
   logic [CHANNELS-1:0]   fifo_empty;
   logic [CHANNELS-1:0]   ovf_rd;
   logic [CHANNELS-1:0]   valid_c;
   logic [CHANNELS-1:0]   a0_c;
   logic [8*CHANNELS-1:0] d_c;
   logic [CHANNELS-1:0]   io_en_c;

   // rd does not qualify register reads: read data is a pure decode of cs/addr
   logic unused_rd;
   assign unused_rd = rd;

   // out-of-range slot values behave as if the cartridge is not selected
   assign slot_ok = (32'(slot) < 32'(CHANNELS));
   assign sel     = slot_ok ? slot : '0;
   assign reg_a   = addr[13:0];

   // one write event per access: rising edge of the qualified write strobe
   assign acc     = cs & wr & mreq & slot_ok;
   assign wr_ev   = acc & ~acc_q;
   assign push    = wr_ev & ((reg_a == 14'h3FF4) | (reg_a == 14'h3FF5));

   // --------------------------------------------------------------------------
   // register writes
   // --------------------------------------------------------------------------
   always_comb begin
      acc_d = acc;
      for (int c = 0; c < CHANNELS; c++) begin
         enable_d[c] = enable_q[c];
         bank_d[c]   = bank_q[c];
         magic_d[c]  = magic_q[c];
      end
      if (wr_ev) begin
         case (reg_a)
            // magic bytes are frozen while enable[4] is set
            14'h1FFE: if (!enable_q[sel][4]) magic_d[sel][7:0]  = d_from_cpu;
            14'h1FFF: if (!enable_q[sel][4]) magic_d[sel][15:8] = d_from_cpu;
            14'h3FF6: begin
               enable_d[sel] = d_from_cpu & 8'h11;
               // leaving the frozen state wipes the unlock key
               if (enable_q[sel][4]) magic_d[sel] = '0;
            end
            14'h3FF7: bank_d[sel] = d_from_cpu[BANK_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            enable_q[c] <= '0;
            bank_q[c]   <= '0;
            magic_q[c]  <= '0;
         end
      end else begin
         acc_q <= acc_d;
         for (int c = 0; c < CHANNELS; c++) begin
            enable_q[c] <= enable_d[c];
            bank_q[c]   <= bank_d[c];
            magic_q[c]  <= magic_d[c];
         end
      end
   end

`ifdef FMPAC_OPLL_FIFO_EN
   // --------------------------------------------------------------------------
   // OPLL write FIFO, one per channel; pointers carry an extra wrap bit
   // --------------------------------------------------------------------------
   localparam int             FAW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [FAW:0]   PTR_ONE  = (FAW+1)'(1);
   localparam logic [FAW:0]   FULL_CNT = (FAW+1)'(FIFO_DEPTH);

   logic [8:0]          mem_q  [CHANNELS][FIFO_DEPTH];
   logic [8:0]          mem_d  [CHANNELS][FIFO_DEPTH];
   logic [FAW:0]        wptr_q [CHANNELS];
   logic [FAW:0]        wptr_d [CHANNELS];
   logic [FAW:0]        rptr_q [CHANNELS];
   logic [FAW:0]        rptr_d [CHANNELS];
   logic [CHANNELS-1:0] ovf_q, ovf_d;
   logic [CHANNELS-1:0] full;
   logic [CHANNELS-1:0] pop;

   always_comb begin
      ovf_d      = ovf_q;
      fifo_empty = '0;
      full       = '0;
      pop        = '0;
      valid_c    = '0;
      a0_c       = '0;
      d_c        = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         wptr_d[c] = wptr_q[c];
         rptr_d[c] = rptr_q[c];
         for (int i = 0; i < FIFO_DEPTH; i++) mem_d[c][i] = mem_q[c][i];

         fifo_empty[c]          = (wptr_q[c] == rptr_q[c]);
         full[c]                = ((wptr_q[c] - rptr_q[c]) == FULL_CNT);
         valid_c[c]             = ~fifo_empty[c];
         {a0_c[c], d_c[8*c +: 8]} = mem_q[c][rptr_q[c][FAW-1:0]];
         pop[c]                 = valid_c[c] & opll.opll_ready[c];

         if (pop[c]) rptr_d[c] = rptr_q[c] + PTR_ONE;

         if (push && (32'(sel) == c)) begin
            // a simultaneous pop frees the slot, so a full FIFO still accepts
            if (!full[c] || pop[c]) begin
               mem_d[c][wptr_q[c][FAW-1:0]] = {addr[0], d_from_cpu};
               wptr_d[c] = wptr_q[c] + PTR_ONE;
            end else begin
               ovf_d[c] = 1'b1;
            end
         end

         if (wr_ev && (reg_a == 14'h3FF8) && (32'(sel) == c)) ovf_d[c] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[c][i] <= '0;
         end
      end else begin
         ovf_q <= ovf_d;
         for (int c = 0; c < CHANNELS; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[c][i] <= mem_d[c][i];
         end
      end
   end

   assign ovf_rd = ovf_q;
`else
   // --------------------------------------------------------------------------
   // direct path: one registered valid pulse per OPLL write
   // --------------------------------------------------------------------------
   logic [CHANNELS-1:0]   vld_q, vld_d;
   logic [CHANNELS-1:0]   a0_q, a0_d;
   logic [8*CHANNELS-1:0] dat_q, dat_d;

   logic [CHANNELS+31:0] unused_fifo;
   assign unused_fifo = {opll.opll_ready, 32'(FIFO_DEPTH)};

   always_comb begin
      vld_d = '0;
      a0_d  = a0_q;
      dat_d = dat_q;
      if (push) begin
         vld_d[sel]          = 1'b1;
         a0_d[sel]           = addr[0];
         dat_d[8*sel +: 8]   = d_from_cpu;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         a0_q  <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         a0_q  <= a0_d;
         dat_q <= dat_d;
      end
   end

   assign fifo_empty = '1;
   assign ovf_rd     = '0;
   assign valid_c    = vld_q;
   assign a0_c       = a0_q;
   assign d_c        = dat_q;
`endif

   // --------------------------------------------------------------------------
   // OPLL lanes
   // --------------------------------------------------------------------------
   always_comb begin
      io_en_c = '0;
      for (int c = 0; c < CHANNELS; c++) io_en_c[c] = enable_q[c][0];
   end

   assign opll.opll_io_enable = io_en_c;
   assign opll.opll_valid     = valid_c;
   assign opll.opll_a0        = a0_c;
   assign opll.opll_d         = d_c;

   // --------------------------------------------------------------------------
   // combinational read / memory decode for the selected channel
   // --------------------------------------------------------------------------
   assign sram_en = (magic_q[sel] == SRAM_MAGIC);

   always_comb begin
      rdata  = 8'hFF;
      rd_hit = 1'b0;
      if (cs && slot_ok) begin
         case (reg_a)
            14'h3FF6: begin rd_hit = 1'b1; rdata = enable_q[sel]; end
            14'h3FF7: begin rd_hit = 1'b1; rdata = 8'(bank_q[sel]); end
            14'h3FF8: begin rd_hit = 1'b1; rdata = {6'b0, fifo_empty[sel], ovf_rd[sel]}; end
            14'h1FFE: if (sram_en) begin rd_hit = 1'b1; rdata = magic_q[sel][7:0]; end
            14'h1FFF: if (sram_en) begin rd_hit = 1'b1; rdata = magic_q[sel][15:8]; end
            default: ;
         endcase
      end
   end

   assign d_to_cpu    = rdata;
   assign cart_oe     = rd_hit;
   assign sram_oe     = cs & slot_ok & sram_en & (addr[13:SRAM_AW] == '0);
   assign sram_we     = sram_oe & wr & mreq;
   assign mem_unmaped = cs & (addr[15:14] != 2'b01);
   assign mem_addr    = sram_oe ? 25'(addr[SRAM_AW-1:0]) : 25'({bank_q[sel], reg_a});

endmodule

// File: doc/fm_pac_mapper_mc.md
# fm_pac_mapper_mc

Multi-channel, parametrised FM-PAC cartridge mapper: it decodes the FM-PAC register window (enable, bank, SRAM magic unlock) for `CHANNELS` independent cartridge instances. It also generates ROM/SRAM memory addresses and buffers OPLL register writes per channel in a small FIFO with a valid/ready handshake towards the OPLL core. It sits between the slot decoder (which supplies `cs` and `slot`) and the shared cartridge memory / OPLL sound block. It supersedes single-pulse OPLL writes and level-sensitive register writes.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent FM-PAC instances (1..4).
- `SRAM_AW`, 13, SRAM window address width; window is 2^SRAM_AW bytes at page offset 0 (10..13).
- `BANK_W`, 2, ROM bank register width (1..4).
- `FIFO_DEPTH`, 4, OPLL write FIFO entries per channel (power of 2, 2..16).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: system clock.
  - `reset_n` in 1: asynchronous active-low reset.
- CPU bus and slot select:
  - `addr` in 16: CPU address.
  - `d_from_cpu` in 8: CPU write data.
  - `d_to_cpu` out 8: register read data; FFh when not driving.
  - `cs` in 1: cartridge slot selected.
  - `slot` in max(1,$clog2(CHANNELS)): channel index; values ≥ CHANNELS are ignored (no access).
  - `wr`, `rd`, `mreq` in 1 each: CPU strobes, active-high.
- Memory interface:
  - `cart_oe` out 1: mapper drives `d_to_cpu`.
  - `sram_oe` out 1: access hits the unlocked SRAM window.
  - `sram_we` out 1: SRAM write strobe.
  - `mem_unmaped` out 1: `cs` with `addr` outside 4000h–7FFFh.
  - `mem_addr` out 25: ROM/SRAM address for the selected channel.
- OPLL write handshake:
  - `opll_io_enable` out CHANNELS: per-channel `enable[0]`.
  - `opll_valid` out CHANNELS: FIFO head valid.
  - `opll_a0` out CHANNELS: head entry register/data select.
  - `opll_d` out 8*CHANNELS: head entry data, channel c at [8c+7:8c].
  - `opll_ready` in CHANNELS: OPLL accepts head.

## Operation
- **Per-channel state:** `enable[7:0]` (only bits 4 and 0 writable), `bank[BANK_W-1:0]`, `magic[15:0]`, sticky `ovf`, FIFO.
- **Write event:** a write event fires on the rising edge of `acc = cs & wr & mreq & slot<CHANNELS`, once per access regardless of strobe length. The detector holds the previous `acc` value in a register.
- **Register decode** on `addr[13:0]`, write event, selected channel:
  - 1FFEh / 1FFFh: `magic[7:0]` / `magic[15:8]` are written only if `enable[4]=0`.
  - 3FF4h / 3FF5h: push `{a0=addr[0], d_from_cpu}` into the FIFO.
  - 3FF6h: `enable <= d & 11h`. If the old `enable[4]=1`, `magic` is cleared in the same cycle.
  - 3FF7h: `bank <= d[BANK_W-1:0]`.
  - 3FF8h: clear `ovf`.
- **Reads** (combinational, selected channel, `cs`):
  - 3FF6h: `enable`.
  - 3FF7h: zero-extended `bank`.
  - 3FF8h: `{6'b0, fifo_empty, ovf}`.
  - 1FFEh / 1FFFh: the `magic` bytes, only when `sram_en`.
  - In all these cases `cart_oe=1`. Otherwise `cart_oe=0` and `d_to_cpu=FFh`.
- **SRAM window:**
  - `sram_en = (magic==694Dh)`.
  - `sram_oe = cs & sram_en & addr[13:SRAM_AW]==0`.
  - `sram_we = sram_oe & wr & mreq` (level).
  - `mem_addr = sram_oe ? zext(addr[SRAM_AW-1:0]) : zext({bank, addr[13:0]})`.
- **FIFO:**
  - Pop on `opll_valid & opll_ready`.
  - Push when full with no simultaneous pop: the entry is dropped and `ovf` is set.
  - Push and pop in the same cycle when full: accepted, count unchanged.
  - Writes to 1FFEh/1FFFh that land in the unlocked SRAM window still update `magic` (register and SRAM both written).

## Timing
- **Reset values:**
  - `enable`, `bank`, `magic`, `ovf`, FIFO pointers and the edge register are 0.
  - Outputs: `opll_valid=0`, `opll_io_enable=0`, `sram_oe/we=0`, `cart_oe=0`, `d_to_cpu=FFh`.
- **Latency:**
  - Registers update on the first `clk` edge where `acc` is high and the previous `acc` was low.
  - `opll_valid` rises 1 cycle after the push edge into an empty FIFO.
- **Handshake:** `opll_valid`, `opll_a0` and `opll_d` are held stable until `opll_ready`. Back-to-back pops are possible, one per cycle.
- **Reset mid-operation:** reset asserted mid-operation discards the FIFO contents immediately (asynchronous). `opll_valid` drops without a handshake.
- **Combinational paths:** `mem_addr`, `sram_*` and read data are combinational from `addr`, `cs` and `slot`, with no added latency.

## Configuration
- `FMPAC_OPLL_FIFO_EN` defined: FIFO and valid/ready handshake as specified; `ovf` is functional.
- Undefined:
  - No FIFO. Each push produces a one-cycle `opll_valid` pulse on the cycle after the write edge, with `opll_a0/opll_d` registered.
  - `opll_ready` is ignored.
  - `ovf` reads 0 and `fifo_empty` reads 1.
  - `FIFO_DEPTH` is unused.

## Test plan
- **Reset defaults:** reset, then read 3FF6h/3FF7h → 00h/00h, `cart_oe=1`. Read 1FFEh → `cart_oe=0`, FFh.
- **SRAM unlock:**
  - Write 4Dh to 5FFEh and 69h to 5FFFh, then access 4123h → `sram_oe=1`, `mem_addr=0123h`. A read of 5FFFh returns 69h.
  - Write 10h to 7FF6h, then 00h to 7FF6h → magic cleared, `sram_oe=0`.
- **Banking:** write 03h to 7FF7h, then access 6000h → `mem_addr=0E000h`. Channel 1 bank is unaffected (still 0).
- **Strobe length:** hold `wr` for 5 cycles on a 7FF4h write → exactly one FIFO entry, and `opll_valid` rises 1 cycle after the edge.
- **FIFO backpressure:**
  - With `opll_ready=0`, perform 5 writes at depth 4 → 4 entries queued and `ovf=1` (3FF8h reads 01h).
  - Raise `opll_ready` → 4 pops in data order; 3FF8h then reads 03h.
  - Write to 3FF8h → reads 02h.
- **Full + simultaneous pop and reset:** push when full during a pop → accepted, `ovf` stays 0. Assert `reset_n=0` mid-drain → `opll_valid=0` immediately.
